// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared state encodings, opcodes, ALU codes and mux selects for the multicycle controller
package ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        EXEC_R   = 4'd2,
        EXEC_I   = 4'd3,
        MEM_ADDR = 4'd4,
        MEM_RD   = 4'd5,
        MEM_WR   = 4'd6,
        WB_ALU   = 4'd7,
        WB_MEM   = 4'd8,
        BRANCH   = 4'd9,
        JAL      = 4'd10,
        TRAP     = 4'd11
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b1000;

    localparam logic [1:0] SRCA_PC    = 2'd0;
    localparam logic [1:0] SRCA_RS1   = 2'd1;
    localparam logic [1:0] SRCA_OLDPC = 2'd2;
    localparam logic [1:0] SRCB_RS2   = 2'd0;
    localparam logic [1:0] SRCB_IMM   = 2'd1;
    localparam logic [1:0] SRCB_FOUR  = 2'd2;
    localparam logic [1:0] RES_ALUOUT = 2'd0;
    localparam logic [1:0] RES_MEM    = 2'd1;
    localparam logic [1:0] RES_ALU    = 2'd2;

    localparam logic PC_ALU    = 1'b0;
    localparam logic PC_ALUOUT = 1'b1;

endpackage

// File: rtl/wait_timer.sv
// wait_timer: 8-bit memory-wait counter; expired when the count reaches the limit
module wait_timer (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       clear_i,
    input  logic       enable_i,
    input  logic [7:0] limit_i,
    output logic       expired_o
);

    logic [7:0] cnt_q, cnt_d;

    always_comb cnt_d = clear_i ? 8'd0 : (enable_i ? cnt_q + 8'd1 : cnt_q);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= 8'd0;
        else         cnt_q <= cnt_d;
    end

    assign expired_o = (cnt_q == limit_i);

endmodule

// File: rtl/ctrl_multiciclo.sv
// ctrl_multiciclo: multicycle RISC-V control FSM with memory-wait timeout trap
module ctrl_multiciclo
    import ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [6:0] opcode_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7b5_i,
    input  logic       zero_i,
    input  logic       imem_ready_i,
    input  logic       dmem_ready_i,
    output logic       pc_we_o,
    output logic       ir_we_o,
    output logic       rf_we_o,
    output logic       imem_req_o,
    output logic       dmem_rd_o,
    output logic       dmem_wr_o,
    output logic [1:0] alusrc_a_o,
    output logic [1:0] alusrc_b_o,
    output logic [3:0] aluop_o,
    output logic       pcsrc_o,
    output logic [1:0] resultsrc_o,
    output logic [3:0] state_o,
    output logic       retired_o,
    output logic       trap_o
);

    state_t state_q, state_d;
    logic   pc_we, ir_we, rf_we, imem_req, dmem_rd, dmem_wr, retired;
    logic   rdy, waiting, expired;

    assign rdy     = (state_q == FETCH) ? imem_ready_i : dmem_ready_i;
    assign waiting = (state_q == FETCH) || (state_q == MEM_RD) || (state_q == MEM_WR);

    // Counter runs only while stalled on memory; any other cycle restarts it
    wait_timer u_timer (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clear_i   (!(waiting && !rdy)),
        .enable_i  (waiting && !rdy),
        .limit_i   (8'(MEM_TIMEOUT)),
        .expired_o (expired)
    );

    always_comb begin
        state_d     = state_q;
        pc_we       = 1'b0;
        ir_we       = 1'b0;
        rf_we       = 1'b0;
        imem_req    = 1'b0;
        dmem_rd     = 1'b0;
        dmem_wr     = 1'b0;
        retired     = 1'b0;
        alusrc_a_o  = SRCA_PC;
        alusrc_b_o  = SRCB_RS2;
        aluop_o     = ALU_ADD;
        pcsrc_o     = PC_ALU;
        resultsrc_o = RES_ALUOUT;
        case (state_q)
            FETCH: begin
                imem_req   = 1'b1;
                alusrc_b_o = SRCB_FOUR;
                ir_we      = imem_ready_i;
                pc_we      = imem_ready_i;
                state_d    = imem_ready_i ? DECODE : (expired ? TRAP : FETCH);
            end
            DECODE: begin
                alusrc_a_o = SRCA_OLDPC;
                alusrc_b_o = SRCB_IMM;
                state_d    = (opcode_i == OP_R)                              ? EXEC_R   :
                             (opcode_i == OP_I)                              ? EXEC_I   :
                             (opcode_i == OP_LOAD || opcode_i == OP_STORE)   ? MEM_ADDR :
                             (opcode_i == OP_BRANCH)                         ? BRANCH   :
                             (opcode_i == OP_JAL)                            ? JAL      : TRAP;
            end
            EXEC_R: begin
                alusrc_a_o = SRCA_RS1;
                aluop_o    = {funct7b5_i, funct3_i};
                state_d    = WB_ALU;
            end
            EXEC_I: begin
                alusrc_a_o = SRCA_RS1;
                alusrc_b_o = SRCB_IMM;
                aluop_o    = {(funct3_i == 3'b101) & funct7b5_i, funct3_i};
                state_d    = WB_ALU;
            end
            MEM_ADDR: begin
                alusrc_a_o = SRCA_RS1;
                alusrc_b_o = SRCB_IMM;
                state_d    = (opcode_i == OP_LOAD) ? MEM_RD : (opcode_i == OP_STORE) ? MEM_WR : TRAP;
            end
            MEM_RD: begin
                dmem_rd = 1'b1;
                state_d = dmem_ready_i ? WB_MEM : (expired ? TRAP : MEM_RD);
            end
            MEM_WR: begin
                dmem_wr = 1'b1;
                retired = dmem_ready_i;
                state_d = dmem_ready_i ? FETCH : (expired ? TRAP : MEM_WR);
            end
            WB_ALU: begin
                rf_we   = 1'b1;
                retired = 1'b1;
                state_d = FETCH;
            end
            WB_MEM: begin
                rf_we       = 1'b1;
                resultsrc_o = RES_MEM;
                retired     = 1'b1;
                state_d     = FETCH;
            end
            BRANCH: begin
                alusrc_a_o = SRCA_RS1;
                aluop_o    = ALU_SUB;
                pcsrc_o    = PC_ALUOUT;
                // funct3[0] selects bne, which inverts the zero test
                pc_we      = (funct3_i[2:1] == 2'b00) && (zero_i ^ funct3_i[0]);
                retired    = (funct3_i[2:1] == 2'b00);
                state_d    = (funct3_i[2:1] == 2'b00) ? FETCH : TRAP;
            end
            JAL: begin
                rf_we   = 1'b1;
                pc_we   = 1'b1;
                pcsrc_o = PC_ALUOUT;
                retired = 1'b1;
                state_d = FETCH;
            end
            default: state_d = TRAP;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= FETCH;
        else         state_q <= state_d;
    end

    // Strobes are gated by reset so an in-flight access aborts without waiting for a clock
    assign pc_we_o    = pc_we & rst_ni;
    assign ir_we_o    = ir_we & rst_ni;
    assign rf_we_o    = rf_we & rst_ni;
    assign imem_req_o = imem_req & rst_ni;
    assign dmem_rd_o  = dmem_rd & rst_ni;
    assign dmem_wr_o  = dmem_wr & rst_ni;
    assign retired_o  = retired & rst_ni;
    assign trap_o     = (state_q == TRAP);
    assign state_o    = state_q;

endmodule
